// File: rtl/sm_run_ctrl.sv
// Run/step/halt controller for the stack machine phase sequencer.
// Issues launches in free-run or single-step, stops on request, HALT or breakpoint, and counts retired instructions.
module sm_run_ctrl #(
  parameter int PC_W  = 16,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_req,
  input  logic             step_req,
  input  logic             stop_req,
  input  logic             cnt_clr,
  input  logic             brk_en,
  input  logic [PC_W-1:0]  brk_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             halt_insn,
  input  logic             s00_idle,
  input  logic             s03_exec,
  input  logic             s04_wtbk,
  output logic             run,
  output logic             running,
  output logic [1:0]       stop_cause,
  output logic [CNT_W-1:0] insn_cnt,
  output logic             cnt_ovf
);

  typedef enum logic [1:0] {
    ST_STOP  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_STEPW = 2'd3
  } state_t;

  localparam logic [1:0] CAUSE_NONE = 2'b00;
  localparam logic [1:0] CAUSE_STOP = 2'b01;
  localparam logic [1:0] CAUSE_HALT = 2'b10;
  localparam logic [1:0] CAUSE_BRK  = 2'b11;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t     state_q, state_d;
  logic       stop_pend_q, stop_pend_d;
  logic       halt_seen_q, halt_seen_d;
  logic       skip_brk_q, skip_brk_d;
  logic [1:0] cause_q, cause_d;
  logic       brk_hit;
  logic       retire;

  always_comb begin
    // NOTE: every always_comb output gets a default before any branch, so no path can infer a latch.
    state_d     = state_q;
    stop_pend_d = stop_pend_q;
    halt_seen_d = halt_seen_q;
    skip_brk_d  = skip_brk_q;
    cause_d     = cause_q;

    brk_hit = brk_en & ~skip_brk_q & (pc == brk_addr);
    run     = s00_idle & (((state_q == ST_RUN) & ~stop_req & ~brk_hit) | (state_q == ST_STEP));
    retire  = s04_wtbk & ((state_q == ST_RUN) | (state_q == ST_STEPW));

    // Resuming at a breakpoint address must execute that instruction once.
    if (run) skip_brk_d = 1'b0;

    unique case (state_q)
      ST_STOP: begin
        if (start_req) begin
          state_d    = ST_RUN;
          skip_brk_d = 1'b1;
        end else if (step_req) begin
          state_d = ST_STEP;
        end
      end
      ST_RUN: begin
        if (halt_insn & s03_exec) halt_seen_d = 1'b1;
        if (s04_wtbk) begin
          stop_pend_d = 1'b0;
          halt_seen_d = 1'b0;
          if (halt_seen_q) begin
            state_d = ST_STOP;
            cause_d = CAUSE_HALT;
          end else if (stop_pend_q | stop_req) begin
            state_d = ST_STOP;
            cause_d = CAUSE_STOP;
          end
        end else if (s00_idle) begin
          if (stop_req) begin
            state_d = ST_STOP;
            cause_d = CAUSE_STOP;
          end else if (brk_hit) begin
            state_d = ST_STOP;
            cause_d = CAUSE_BRK;
          end
        end else if (stop_req) begin
          stop_pend_d = 1'b1;
        end
      end
      ST_STEP: begin
        if (s00_idle) begin
          state_d = ST_STEPW;
        end else if (stop_req) begin
          state_d = ST_STOP;
          cause_d = CAUSE_STOP;
        end
      end
      ST_STEPW: begin
        if (halt_insn & s03_exec) halt_seen_d = 1'b1;
        if (s04_wtbk) begin
          state_d     = ST_STOP;
          cause_d     = halt_seen_q ? CAUSE_HALT : CAUSE_NONE;
          halt_seen_d = 1'b0;
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_STOP;
      stop_pend_q <= 1'b0;
      halt_seen_q <= 1'b0;
      skip_brk_q  <= 1'b0;
      cause_q     <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      stop_pend_q <= stop_pend_d;
      halt_seen_q <= halt_seen_d;
      skip_brk_q  <= skip_brk_d;
      cause_q     <= cause_d;
    end
  end

  // Clear wins over a same-cycle retire; overflow is sticky until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      insn_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (cnt_clr) begin
      insn_cnt <= '0;
      cnt_ovf  <= 1'b0;
    end else if (retire) begin
      insn_cnt <= insn_cnt + CNT_ONE;
      if (insn_cnt == '1) cnt_ovf <= 1'b1;
    end
  end

  assign running    = (state_q != ST_STOP);
  assign stop_cause = cause_q;

endmodule

// File: tb/tb_sm_run_ctrl.sv
// Self-checking bench for sm_run_ctrl: a behavioural phase sequencer drives the phase strobes,
// and a rule-level reference model predicts run and the registered outputs every cycle.
module tb_sm_run_ctrl;

  localparam int PC_W  = 16;
  localparam int CNT_W = 4;
  localparam int CNT_MOD = 1 << CNT_W;

  logic             clk;
  logic             rst_n;
  logic             start_req, step_req, stop_req, cnt_clr;
  logic             brk_en;
  logic [PC_W-1:0]  brk_addr;
  logic [PC_W-1:0]  pc;
  logic             halt_insn;
  logic             s00_idle, s03_exec, s04_wtbk;
  logic             run, running;
  logic [1:0]       stop_cause;
  logic [CNT_W-1:0] insn_cnt;
  logic             cnt_ovf;

  sm_run_ctrl #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_req  (start_req),
    .step_req   (step_req),
    .stop_req   (stop_req),
    .cnt_clr    (cnt_clr),
    .brk_en     (brk_en),
    .brk_addr   (brk_addr),
    .pc         (pc),
    .halt_insn  (halt_insn),
    .s00_idle   (s00_idle),
    .s03_exec   (s03_exec),
    .s04_wtbk   (s04_wtbk),
    .run        (run),
    .running    (running),
    .stop_cause (stop_cause),
    .insn_cnt   (insn_cnt),
    .cnt_ovf    (cnt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Environment: sequencer phase 0..4 (0 idle, 3 exec, 4 wtbk), program counter source, HALT source.
  int              ph;
  int              launches, wtbks, cycle, runs_seen;
  int              last_launch_cyc, last_wtbk_cyc;
  logic [PC_W-1:0] pc_v;
  bit              pc_hold, pc_rand, halt_rand, halt_flag;
  int              halt_at;

  // Reference model built from the controller's rules.
  typedef enum int {M_STOP, M_RUN, M_STEP, M_STEPW} mmode_t;
  mmode_t m_mode;
  bit     m_pend, m_halt, m_skip, m_ovf;
  int     m_cause, m_cnt;

  task automatic model_reset();
    m_mode  = M_STOP;
    m_pend  = 0;
    m_halt  = 0;
    m_skip  = 0;
    m_ovf   = 0;
    m_cause = 0;
    m_cnt   = 0;
  endtask

  function automatic bit model_brk();
    return brk_en && !m_skip && (pc == brk_addr);
  endfunction

  function automatic bit model_run();
    if (!s00_idle) return 0;
    if (m_mode == M_STEP) return 1;
    return (m_mode == M_RUN) && !stop_req && !model_brk();
  endfunction

  task automatic model_step();
    bit brk    = model_brk();
    bit launch = model_run();
    bit retire = s04_wtbk && (m_mode == M_RUN || m_mode == M_STEPW);
    if (cnt_clr) begin
      m_cnt = 0;
      m_ovf = 0;
    end else if (retire) begin
      m_cnt = m_cnt + 1;
      if (m_cnt == CNT_MOD) begin
        m_cnt = 0;
        m_ovf = 1;
      end
    end
    if (launch) m_skip = 0;
    case (m_mode)
      M_STOP: begin
        if (start_req) begin
          m_mode = M_RUN;
          m_skip = 1;
        end else if (step_req) begin
          m_mode = M_STEP;
        end
      end
      M_RUN: begin
        if (s04_wtbk) begin
          if (m_halt) begin
            m_mode = M_STOP; m_cause = 2;
          end else if (m_pend || stop_req) begin
            m_mode = M_STOP; m_cause = 1;
          end
          m_pend = 0;
          m_halt = 0;
        end else if (s00_idle) begin
          if (stop_req) begin
            m_mode = M_STOP; m_cause = 1;
          end else if (brk) begin
            m_mode = M_STOP; m_cause = 3;
          end
        end else begin
          if (stop_req) m_pend = 1;
          if (halt_insn && s03_exec) m_halt = 1;
        end
      end
      M_STEP: begin
        if (s00_idle) m_mode = M_STEPW;
        else if (stop_req) begin
          m_mode = M_STOP; m_cause = 1;
        end
      end
      M_STEPW: begin
        if (halt_insn && s03_exec) m_halt = 1;
        if (s04_wtbk) begin
          m_mode  = M_STOP;
          m_cause = m_halt ? 2 : 0;
          m_halt  = 0;
        end
      end
    endcase
  endtask

  // One clock cycle: present phases, compare against the model mid-cycle, advance at the edge.
  task automatic tick();
    bit run_s;
    s00_idle  = (ph == 0);
    s03_exec  = (ph == 3);
    s04_wtbk  = (ph == 4);
    pc        = pc_v;
    halt_insn = (ph == 3) ? halt_flag : 1'($urandom_range(0, 1));
    #2;
    run_s = run;
    checks++;
    if (run !== model_run()) begin
      failures++;
      $display("FAIL run cyc=%0d got=%b exp=%b", cycle, run, model_run());
    end
    checks++;
    if (running !== (m_mode != M_STOP)) begin
      failures++;
      $display("FAIL running cyc=%0d got=%b exp=%b", cycle, running, (m_mode != M_STOP));
    end
    checks++;
    if (stop_cause !== 2'(m_cause)) begin
      failures++;
      $display("FAIL stop_cause cyc=%0d got=%0d exp=%0d", cycle, stop_cause, m_cause);
    end
    checks++;
    if (insn_cnt !== CNT_W'(m_cnt)) begin
      failures++;
      $display("FAIL insn_cnt cyc=%0d got=%0d exp=%0d", cycle, insn_cnt, m_cnt);
    end
    checks++;
    if (cnt_ovf !== m_ovf) begin
      failures++;
      $display("FAIL cnt_ovf cyc=%0d got=%b exp=%b", cycle, cnt_ovf, m_ovf);
    end
    @(posedge clk);
    model_step();
    if (run_s) runs_seen++;
    if (ph == 0 && run_s) begin
      launches++;
      last_launch_cyc = cycle;
      halt_flag = halt_rand ? ($urandom_range(0, 7) == 0) : (launches == halt_at);
    end
    if (ph == 4) begin
      wtbks++;
      last_wtbk_cyc = cycle;
      if (pc_rand) pc_v = PC_W'($urandom_range(0, 7));
      else if (!pc_hold) pc_v = pc_v + 1'b1;
    end
    if (ph == 0) ph = run_s ? 1 : 0;
    else if (ph == 4) ph = 0;
    else ph = ph + 1;
    cycle++;
    #1;
    start_req = 0;
    step_req  = 0;
    stop_req  = 0;
    cnt_clr   = 0;
  endtask

  task automatic wait_stop(input string name, input int budget);
    for (int i = 0; i < budget && m_mode != M_STOP; i++) tick();
    checks++;
    if (m_mode != M_STOP) begin
      failures++;
      $display("FAIL %s_timeout got=running exp=stopped within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    start_req = 1;
    step_req  = 1;
    #2;
    model_reset();
    ph = 0;
    @(posedge clk);
    #1;
    checks++;
    if ({run, running, stop_cause, insn_cnt, cnt_ovf} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=run%b running%b cause%0d cnt%0d ovf%b exp=all zero",
               run, running, stop_cause, insn_cnt, cnt_ovf);
    end
    start_req = 0;
    step_req  = 0;
    rst_n = 1;
    tick();
  endtask

  task automatic test_step();
    int r0 = runs_seen;
    pc_v = 16'h0010;
    step_req = 1;
    tick();
    for (int i = 0; i < 15; i++) tick();
    checks++;
    if (runs_seen - r0 != 1) begin
      failures++;
      $display("FAIL step_run_pulses got=%0d exp=1", runs_seen - r0);
    end
    checks++;
    if (insn_cnt !== 4'd1 || stop_cause !== 2'b00 || running !== 1'b0) begin
      failures++;
      $display("FAIL step_result got=cnt%0d cause%0d running%b exp=cnt1 cause0 running0",
               insn_cnt, stop_cause, running);
    end
  endtask

  task automatic test_run_stop();
    int l0 = launches;
    int c_first = -1;
    int i;
    start_req = 1;
    tick();
    for (i = 0; i < 100 && !(ph == 3 && launches - l0 == 5); i++) begin
      tick();
      if (c_first < 0 && launches > l0) c_first = last_launch_cyc;
    end
    checks++;
    if (i >= 100) begin
      failures++;
      $display("FAIL runstop_reach_5th got=%0d launches exp=5", launches - l0);
    end
    stop_req = 1;
    tick();
    wait_stop("runstop", 20);
    checks++;
    if (launches - l0 != 5 || insn_cnt !== 4'd6 || stop_cause !== 2'b01) begin
      failures++;
      $display("FAIL runstop_result got=launch%0d cnt%0d cause%0d exp=launch5 cnt6 cause1",
               launches - l0, insn_cnt, stop_cause);
    end
    checks++;
    if (last_wtbk_cyc - c_first != 24) begin
      failures++;
      $display("FAIL runstop_no_dead_cycles got=%0d cycles exp=24", last_wtbk_cyc - c_first);
    end
  endtask

  task automatic test_breakpoint();
    int l0;
    cnt_clr = 1;
    tick();
    pc_v = '0;
    brk_en = 1;
    brk_addr = 16'h0003;
    start_req = 1;
    tick();
    wait_stop("brk1", 100);
    checks++;
    if (insn_cnt !== 4'd3 || stop_cause !== 2'b11 || run !== 1'b0) begin
      failures++;
      $display("FAIL brk_first_hit got=cnt%0d cause%0d run%b exp=cnt3 cause3 run0",
               insn_cnt, stop_cause, run);
    end
    pc_hold = 1;
    l0 = launches;
    start_req = 1;
    tick();
    wait_stop("brk2", 100);
    checks++;
    if (launches - l0 != 1 || insn_cnt !== 4'd4 || stop_cause !== 2'b11) begin
      failures++;
      $display("FAIL brk_resume got=launch%0d cnt%0d cause%0d exp=launch1 cnt4 cause3",
               launches - l0, insn_cnt, stop_cause);
    end
    pc_hold = 0;
    brk_en = 0;
  endtask

  task automatic test_halt();
    cnt_clr = 1;
    tick();
    halt_at = launches + 2;
    start_req = 1;
    tick();
    wait_stop("halt", 100);
    checks++;
    if (insn_cnt !== 4'd2 || stop_cause !== 2'b10) begin
      failures++;
      $display("FAIL halt_result got=cnt%0d cause%0d exp=cnt2 cause2", insn_cnt, stop_cause);
    end
    halt_at = -1;
  endtask

  task automatic test_overflow();
    int l0;
    int i;
    cnt_clr = 1;
    tick();
    l0 = launches;
    start_req = 1;
    tick();
    for (i = 0; i < 200 && !(ph == 3 && launches - l0 == 16); i++) tick();
    checks++;
    if (i >= 200) begin
      failures++;
      $display("FAIL ovf_reach_16th got=%0d launches exp=16", launches - l0);
    end
    stop_req = 1;
    tick();
    wait_stop("ovf", 20);
    checks++;
    if (insn_cnt !== 4'd0 || cnt_ovf !== 1'b1) begin
      failures++;
      $display("FAIL ovf_wrap got=cnt%0d ovf%b exp=cnt0 ovf1", insn_cnt, cnt_ovf);
    end
    start_req = 1;
    tick();
    for (i = 0; i < 20 && ph != 4; i++) tick();
    cnt_clr = 1;
    tick();
    checks++;
    if (insn_cnt !== 4'd0 || cnt_ovf !== 1'b0) begin
      failures++;
      $display("FAIL clr_beats_retire got=cnt%0d ovf%b exp=cnt0 ovf0", insn_cnt, cnt_ovf);
    end
    stop_req = 1;
    tick();
    wait_stop("clr", 20);
  endtask

  task automatic test_mid_reset();
    int l0 = launches;
    int i;
    start_req = 1;
    tick();
    for (i = 0; i < 100 && !(ph == 3 && launches - l0 == 3); i++) tick();
    s00_idle = 0;
    s03_exec = 1;
    s04_wtbk = 0;
    rst_n = 0;
    #1;
    checks++;
    if ({run, running, stop_cause, insn_cnt, cnt_ovf} !== '0) begin
      failures++;
      $display("FAIL mid_reset got=run%b running%b cause%0d cnt%0d ovf%b exp=all zero",
               run, running, stop_cause, insn_cnt, cnt_ovf);
    end
    model_reset();
    ph = 0;
    @(posedge clk);
    #1;
    rst_n = 1;
    tick();
  endtask

  task automatic test_random();
    pc_rand   = 1;
    halt_rand = 1;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) begin
        brk_en   = 1'($urandom_range(0, 1));
        brk_addr = PC_W'($urandom_range(0, 7));
      end
      start_req = ($urandom_range(0, 15) == 0);
      step_req  = ($urandom_range(0, 15) == 0);
      stop_req  = ($urandom_range(0, 11) == 0);
      cnt_clr   = ($urandom_range(0, 63) == 0);
      tick();
    end
    pc_rand   = 0;
    halt_rand = 0;
    halt_flag = 0;
    brk_en    = 0;
    stop_req  = 1;
    tick();
    wait_stop("random_drain", 20);
  endtask

  initial begin
    rst_n = 1;
    {start_req, step_req, stop_req, cnt_clr, brk_en, halt_insn} = '0;
    {s00_idle, s03_exec, s04_wtbk} = '0;
    brk_addr = '0;
    pc = '0;
    pc_v = '0;
    {pc_hold, pc_rand, halt_rand, halt_flag} = '0;
    halt_at = -1;
    ph = 0;
    launches = 0; wtbks = 0; cycle = 0; runs_seen = 0;
    last_launch_cyc = 0; last_wtbk_cyc = 0;
    model_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_step();
    test_run_stop();
    test_breakpoint();
    test_halt();
    test_overflow();
    test_mid_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
